// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide unit for the execute stage. Owns HI/LO.
//   MULT/MULTU/DIV/DIVU run over WIDTH+2 cycles and hold the PC via Stall.
//   MFHI/MFLO/MTHI/MTLO complete in a single cycle.
//
// Ports
//   CLK     in   1      clock, rising edge
//   RST     in   1      asynchronous active-low reset
//   Ins     in   32     current instruction (held by the core while Stall=1)
//   Rdata1  in   WIDTH  rs: dividend / multiplicand / MTHI/MTLO source
//   Rdata2  in   WIDTH  rt: divisor / multiplier
//   Result  out  WIDTH  HI for MFHI, LO for MFLO, 0 otherwise
//   Stall   out  1      hold PC and block writeback this cycle
//   Busy    out  1      FSM is in BUSY
//   State   out  2      raw FSM state (IDLE=0, BUSY=1, DONE=2) for debug
//
// Handshake: the core presents an instruction on Ins and treats it as
// accepted on the first rising edge where Stall=0; until then it must hold
// Ins/Rdata1/Rdata2 stable. An MD instruction is accepted on the edge that
// leaves DONE, which is also the edge that writes HI/LO.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Ins,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic [WIDTH-1:0] Result,
    output logic             Stall,
    output logic             Busy,
    output logic [1:0]       State
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] R_FORM  = 6'h00;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // ---------------- decode ----------------
    logic       r_form;
    logic [5:0] funct;
    logic       is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic       is_mult, is_multu, is_div, is_divu, is_md;
    logic       unused_ins;

    assign r_form     = (Ins[31:26] == R_FORM);
    assign funct      = Ins[5:0];
    assign unused_ins = ^Ins[25:6];

    assign is_mfhi  = r_form && (funct == F_MFHI);
    assign is_mflo  = r_form && (funct == F_MFLO);
    assign is_mthi  = r_form && (funct == F_MTHI);
    assign is_mtlo  = r_form && (funct == F_MTLO);
    assign is_mult  = r_form && (funct == F_MULT);
    assign is_multu = r_form && (funct == F_MULTU);
    assign is_div   = r_form && (funct == F_DIV);
    assign is_divu  = r_form && (funct == F_DIVU);
    assign is_md    = is_mult || is_multu || is_div || is_divu;

    // ---------------- registers ----------------
    logic [WIDTH-1:0]   hi, lo;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;        // mul: {partial sum, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opa, opb;   // operand magnitudes
    logic               sign_a, sign_b;
    logic               op_div, op_signed;

    // ---------------- operand capture ----------------
    logic             ld_signed, ld_div;
    logic             ld_neg_a, ld_neg_b;
    logic [WIDTH-1:0] ld_mag_a, ld_mag_b;

    assign ld_signed = is_mult || is_div;
    assign ld_div    = is_div || is_divu;
    assign ld_neg_a  = ld_signed && Rdata1[WIDTH-1];
    assign ld_neg_b  = ld_signed && Rdata2[WIDTH-1];
    // Negating the most negative value yields itself, which read unsigned
    // is exactly its magnitude.
    assign ld_mag_a  = ld_neg_a ? (~Rdata1 + 1'b1) : Rdata1;
    assign ld_mag_b  = ld_neg_b ? (~Rdata2 + 1'b1) : Rdata2;

    // ---------------- one radix-2 step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul_next;
    logic [WIDTH:0]     div_rem_w;
    logic [WIDTH:0]     div_trial;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem_new;
    logic [2*WIDTH-1:0] acc_div_next;

    // Multiply: add multiplicand into the upper half when the LSB of the
    // multiplier is set, then shift the whole accumulator right.
    assign mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
    assign acc_mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift {rem, dividend} left by one, trial-subtract
    // the divisor; keep the difference and set the quotient bit if no borrow.
    assign div_rem_w    = acc[2*WIDTH-1:WIDTH-1];
    assign div_trial    = div_rem_w - {1'b0, opb};
    assign div_fits     = ~div_trial[WIDTH];
    assign div_rem_new  = div_fits ? div_trial[WIDTH-1:0] : div_rem_w[WIDTH-1:0];
    assign acc_div_next = {div_rem_new, acc[WIDTH-2:0], div_fits};

    // ---------------- sign correction ----------------
    logic               neg_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix, orig_a;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign neg_q    = op_signed && (sign_a ^ sign_b);
    assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    assign quo_fix  = neg_q ? (~quo + 1'b1) : quo;
    assign rem_fix  = (op_signed && sign_a) ? (~rem + 1'b1) : rem;
    // Rebuild the dividend exactly as it arrived on Rdata1.
    assign orig_a   = (op_signed && sign_a) ? (~opa + 1'b1) : opa;

    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (opb == '0) begin
                fin_hi = orig_a;
                fin_lo = DIV0_LO;
            end else begin
                fin_hi = rem_fix;
                fin_lo = quo_fix;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_md) begin
                    Stall      = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                Stall = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state_next = S_DONE;
                end
            end
            // DONE releases the PC; the MD instruction still on Ins this
            // cycle must not start a second operation.
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Stall must read low while reset is asserted, even if an MD
        // instruction is sitting on Ins.
        if (!RST) begin
            Stall = 1'b0;
        end
    end

    assign Busy  = (state == S_BUSY);
    assign State = state;

    // ---------------- datapath ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_md) begin
                        opa       <= ld_mag_a;
                        opb       <= ld_mag_b;
                        sign_a    <= ld_neg_a;
                        sign_b    <= ld_neg_b;
                        op_div    <= ld_div;
                        op_signed <= ld_signed;
                        count     <= '0;
                        acc       <= {{WIDTH{1'b0}}, (ld_div ? ld_mag_a : ld_mag_b)};
                    end else if (is_mthi) begin
                        hi <= Rdata1;
                    end else if (is_mtlo) begin
                        lo <= Rdata1;
                    end
                end
                S_BUSY: begin
                    acc   <= op_div ? acc_div_next : acc_mul_next;
                    count <= count + 1'b1;
                end
                S_DONE: begin
                    hi <= fin_hi;
                    lo <= fin_lo;
                end
                default: ;
            endcase
        end
    end

    // ---------------- result mux ----------------
    always_comb begin
        Result = '0;
        if (is_mfhi) begin
            Result = hi;
        end else if (is_mflo) begin
            Result = lo;
        end
    end

endmodule
